// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared state enum, trunk widths and strobe index helper
package frame_cfg_pkg;

  localparam int FRAME_BITS_PER_ROW = 32;
  localparam int MAX_FRAMES_PER_COL = 20;
  localparam int NUM_COLUMNS        = 4;
  localparam int COL_BITS           = 2;
  localparam int FRAME_IDX_BITS     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  function automatic int strobe_index(input int col, input int frame, input int frames_per_col);
    return col * frames_per_col + frame;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - registered one-hot decode of (col, frame, enable)
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int NumColumns      = NUM_COLUMNS,
  parameter int MaxFramesPerCol = MAX_FRAMES_PER_COL,
  parameter int ColBits         = COL_BITS,
  parameter int FrameIdxBits    = FRAME_IDX_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ColBits-1:0]                    col,
  input  logic [FrameIdxBits-1:0]               frame,
  input  logic                                  enable,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  localparam int NumStrobes = NumColumns * MaxFramesPerCol;

  logic [NumStrobes-1:0] strobe_d;
  int                    idx;

  always_comb begin
    idx      = strobe_index(int'(col), int'(frame), MaxFramesPerCol);
    strobe_d = '0;
    for (int i = 0; i < NumStrobes; i++) begin
      strobe_d[i] = enable && (i == idx);
    end
  end

  // Registered so the trunk strobe never glitches while the index settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= '0;
    end else begin
      strobe <= strobe_d;
    end
  end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// rtl/frame_strobe_sequencer.sv - frame-write sequencer driving FrameData/FrameStrobe trunks
module frame_strobe_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = FRAME_BITS_PER_ROW,
  parameter int MaxFramesPerCol = MAX_FRAMES_PER_COL,
  parameter int NumColumns      = NUM_COLUMNS,
  parameter int ColBits         = COL_BITS,
  parameter int FrameIdxBits    = FRAME_IDX_BITS,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1,
  parameter int HoldCycles      = 1
) (
  input  logic                                  UserCLK,
  input  logic                                  Reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [ColBits-1:0]                    cmd_col,
  input  logic [FrameIdxBits-1:0]               cmd_frame,
  input  logic [FrameBitsPerRow-1:0]            cmd_data,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_addr,
  input  logic                                  err_clr,
  output logic [7:0]                            frames_written
);

  localparam int MaxCycles = max3(SetupCycles, StrobeCycles, HoldCycles);
  localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] SetupLoad  = CntW'(SetupCycles - 1);
  localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeCycles - 1);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HoldCycles - 1);

  seq_state_t                 state, state_next;
  logic [CntW-1:0]            cnt, cnt_next;
  logic [ColBits-1:0]         col_q;
  logic [FrameIdxBits-1:0]    frame_q;
  logic [FrameBitsPerRow-1:0] data_q;
  logic                       addr_ok;
  logic                       take;
  logic                       bad;
  logic                       finish;

  assign addr_ok = (int'(cmd_col) < NumColumns) && (int'(cmd_frame) < MaxFramesPerCol);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    take       = 1'b0;
    bad        = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (addr_ok) begin
            take       = 1'b1;
            state_next = SETUP;
            cnt_next   = SetupLoad;
          end else begin
            bad = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_next = STROBE;
          cnt_next   = StrobeLoad;
        end else begin
          cnt_next = cnt - CntW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_next = HOLD;
          cnt_next   = HoldLoad;
        end else begin
          cnt_next = cnt - CntW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else begin
          cnt_next = cnt - CntW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state          <= IDLE;
      cnt            <= '0;
      col_q          <= '0;
      frame_q        <= '0;
      data_q         <= '0;
      done           <= 1'b0;
      err_addr       <= 1'b0;
      frames_written <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= finish;
      if (take) begin
        col_q   <= cmd_col;
        frame_q <= cmd_frame;
        data_q  <= cmd_data;
      end else if (finish) begin
        data_q <= '0;
      end
      // A fresh address error outranks a clear in the same cycle.
      if (bad) begin
        err_addr <= 1'b1;
      end else if (err_clr) begin
        err_addr <= 1'b0;
      end
      if (finish && frames_written != 8'hFF) begin
        frames_written <= frames_written + 8'd1;
      end
    end
  end

  // Latched col/frame are stable by the time SETUP hands over to STROBE.
  frame_strobe_decoder #(
    .NumColumns     (NumColumns),
    .MaxFramesPerCol(MaxFramesPerCol),
    .ColBits        (ColBits),
    .FrameIdxBits   (FrameIdxBits)
  ) u_decoder (
    .clk   (UserCLK),
    .rst   (Reset),
    .col   (col_q),
    .frame (frame_q),
    .enable(state_next == STROBE),
    .strobe(FrameStrobe)
  );

  assign FrameData = data_q;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb/tb_frame_strobe_sequencer.sv - scoreboard bench for frame_strobe_sequencer
module tb_frame_strobe_sequencer;

  localparam int NC  = 4;
  localparam int MF  = 20;
  localparam int FB  = 32;
  localparam int CB  = 2;
  localparam int FIB = 5;
  localparam int S   = 1;
  localparam int T   = 1;
  localparam int H   = 1;
  localparam int TOT = S + T + H;
  localparam int NS  = NC * MF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [CB-1:0]  cmd_col = '0;
  logic [FIB-1:0] cmd_frame = '0;
  logic [FB-1:0]  cmd_data = '0;
  logic [FB-1:0]  FrameData;
  logic [NS-1:0]  FrameStrobe;
  logic           busy, done, err_addr;
  logic           err_clr = 1'b0;
  logic [7:0]     frames_written;

  logic           cmd_valid_b = 1'b0;
  logic           cmd_ready_b;
  logic [CB-1:0]  cmd_col_b = '0;
  logic [FIB-1:0] cmd_frame_b = '0;
  logic [FB-1:0]  cmd_data_b = '0;
  logic [FB-1:0]  FrameData_b;
  logic [NS-1:0]  FrameStrobe_b;
  logic           busy_b, done_b, err_addr_b;
  logic [7:0]     frames_written_b;

  frame_strobe_sequencer dut (
    .UserCLK(clk), .Reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .cmd_data(cmd_data),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done),
    .err_addr(err_addr), .err_clr(err_clr), .frames_written(frames_written)
  );

  frame_strobe_sequencer #(.SetupCycles(2), .StrobeCycles(3), .HoldCycles(2)) dut_b (
    .UserCLK(clk), .Reset(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_col(cmd_col_b), .cmd_frame(cmd_frame_b), .cmd_data(cmd_data_b),
    .FrameData(FrameData_b), .FrameStrobe(FrameStrobe_b), .busy(busy_b), .done(done_b),
    .err_addr(err_addr_b), .err_clr(1'b0), .frames_written(frames_written_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model: phase = cycles since the accepting edge, 0 when idle.
  int          ph = 0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  int          m_fw = 0;
  logic        m_done = 1'b0;
  int          n_cmds = 0;

  task automatic model_edge();
    logic set_err;
    wr_t  w;
    set_err = 1'b0;
    if (rst) begin
      ph = 0; m_data = '0; m_err = 1'b0; m_fw = 0; m_done = 1'b0;
    end else begin
      m_done = (ph == TOT);
      if (m_done && m_fw < 255) m_fw++;
      if (ph == 0) begin
        if (cmd_valid) begin
          n_cmds++;
          if (int'(cmd_col) < NC && int'(cmd_frame) < MF) begin
            ph     = 1;
            m_data = cmd_data;
            w.idx  = int'(cmd_col) * MF + int'(cmd_frame);
            w.data = cmd_data;
            exp_q.push_back(w);
          end else begin
            set_err = 1'b1;
          end
        end
      end else if (ph == TOT) begin
        ph = 0;
        m_data = '0;
      end else begin
        ph++;
      end
      if (set_err) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  endtask

  task automatic check_cycle();
    check("cmd_ready", cmd_ready, ph == 0);
    check("busy", busy, ph != 0);
    check("done", done, m_done);
    check("frame_data", FrameData, (ph != 0) ? m_data : 32'd0);
    check("strobe_active", FrameStrobe != '0, (ph > S) && (ph <= S + T));
    check("err_addr", err_addr, m_err);
    check("frames_written", frames_written, m_fw);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  function automatic int find_idx(input logic [NS-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NS; i++) if (v[i]) r = i;
    return r;
  endfunction

  logic [NS-1:0] mon_prev = '0;
  int            mon_run = 0;
  wr_t           mon_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (FrameStrobe != '0) begin
        check("strobe_onehot", $onehot(FrameStrobe), 1'b1);
        if (mon_prev == '0) begin
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", find_idx(FrameStrobe), -1);
          end else begin
            mon_e = exp_q.pop_front();
            check("strobe_idx", find_idx(FrameStrobe), mon_e.idx);
            check("strobe_data", FrameData, mon_e.data);
          end
          mon_run = 1;
        end else begin
          mon_run++;
        end
      end else if (mon_prev != '0) begin
        check("strobe_len", mon_run, T);
      end
      mon_prev = FrameStrobe;
    end
  end

  initial begin : driver
    int start;
    int bound;
    step();
    step();
    rst = 1'b0;

    // Slow-timing instance: single write plus busy-time command churn.
    cmd_valid_b = 1'b1; cmd_col_b = 2'd0; cmd_frame_b = 5'd0; cmd_data_b = 32'hCAFE0001;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("b_frame_data", FrameData_b, (c <= 7) ? 32'hCAFE0001 : 32'd0);
      check("b_strobe0", FrameStrobe_b[0], (c >= 3) && (c <= 5));
      check("b_strobe_other", FrameStrobe_b[NS-1:1] != '0, 1'b0);
      check("b_done", done_b, c == 8);
      check("b_ready", cmd_ready_b, c >= 8);
      if (c == 9) check("b_frames_written", frames_written_b, 8'd1);
      cmd_col_b = 2'($urandom_range(0, 3));
      cmd_frame_b = 5'($urandom_range(0, 19));
      cmd_data_b = $urandom();
      if (c == 7) cmd_valid_b = 1'b0;
    end

    // Directed write col 1 frame 3.
    cmd_valid = 1'b1; cmd_col = 2'd1; cmd_frame = 5'd3; cmd_data = 32'hDEADBEEF;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();

    // Out-of-range frame immediately followed by a valid write to col 3.
    cmd_valid = 1'b1; cmd_col = 2'd0; cmd_frame = 5'd20; cmd_data = 32'h0BAD0BAD;
    step();
    cmd_col = 2'd3; cmd_frame = 5'd0; cmd_data = 32'h600D600D;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();

    // Reset during the strobe cycle aborts the write.
    cmd_valid = 1'b1; cmd_col = 2'd2; cmd_frame = 5'd7; cmd_data = 32'h13579BDF;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Back-to-back random commands with data churn while busy.
    start = n_cmds;
    bound = 0;
    cmd_valid = 1'b1;
    while (n_cmds < start + 300 && bound < 5000) begin
      cmd_col   = 2'($urandom_range(0, 3));
      cmd_frame = 5'($urandom_range(0, 20));
      cmd_data  = $urandom();
      err_clr   = ($urandom_range(0, 7) == 0);
      step();
      bound++;
    end
    if (bound >= 5000) check("random_phase_timeout", bound, 0);
    cmd_valid = 1'b0;
    err_clr = 1'b0;
    repeat (6) step();
    check("fw_saturated", frames_written, 8'd255);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
